fpu_result_scoreboard: RTL and testbench



---
 rtl/fpu_result_scoreboard_pkg.sv | 41 ++++
 rtl/fpu_result_scoreboard_if.sv | 23 ++
 rtl/fpu_sb_lane_cmp.sv | 34 +++
 rtl/fpu_result_scoreboard.sv | 118 +++++++++++
 tb/tb_fpu_result_scoreboard.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_result_scoreboard_pkg.sv
// fpnew_pkg: format enumeration and width helpers shared with the FPnew bench.
// fpu_sb_pkg: scoreboard entry type and per-lane helpers.
package fpnew_pkg;
  typedef enum logic [2:0] {
    FP32    = 3'd0,
    FP64    = 3'd1,
    FP16    = 3'd2,
    FP8     = 3'd3,
    FP16ALT = 3'd4,
    FP8ALT  = 3'd5
  } fp_format_e;
  // Unused encodings fall back to the widest format so they get an exact compare.
  function automatic int unsigned fp_width(fp_format_e fmt);
    return (fmt == FP32) ? 32 : (fmt == FP16 || fmt == FP16ALT) ? 16 : (fmt == FP8 || fmt == FP8ALT) ? 8 : 64;
  endfunction
  function automatic int unsigned exp_bits(fp_format_e fmt);
    return (fmt == FP32 || fmt == FP16ALT) ? 8 : (fmt == FP16 || fmt == FP8) ? 5 : (fmt == FP8ALT) ? 4 : 11;
  endfunction
endpackage

package fpu_sb_pkg;
  import fpnew_pkg::*;
  localparam int unsigned SB_WIDTH = 32;
  typedef struct packed {
    logic [SB_WIDTH-1:0]   expected;
    logic [3*SB_WIDTH-1:0] operands;
    fp_format_e            dst_fmt;
  } sb_entry_t;
  // Zero lanes means the format does not fit the datapath and needs a full-word compare.
  function automatic int unsigned lanes(fp_format_e fmt, int unsigned width = SB_WIDTH);
    return (fp_width(fmt) > width) ? 0 : width / fp_width(fmt);
  endfunction
  function automatic logic is_nan(logic [63:0] lane, fp_format_e fmt);
    int unsigned eb = exp_bits(fmt);
    int unsigned mb = fp_width(fmt) - 1 - eb;
    logic [63:0] ones = (64'd1 << eb) - 64'd1;
    logic [63:0] e = (lane >> mb) & ones;
    logic [63:0] m = lane & ((64'd1 << mb) - 64'd1);
    return (e == ones) && (m != 64'd0);
  endfunction
endpackage

// File: rtl/fpu_result_scoreboard_if.sv
// fpu_result_scoreboard_if: observed FPU issue and result handshakes.
interface fpu_result_scoreboard_if
  import fpnew_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();
  logic               issue_valid;
  logic               issue_ready;
  logic [WIDTH-1:0]   issue_expected;
  logic [3*WIDTH-1:0] issue_operands;
  fp_format_e         issue_dst_fmt;
  logic               result_valid;
  logic               result_ready;
  logic [WIDTH-1:0]   result;
  modport master (
    output issue_valid, issue_ready, issue_expected, issue_operands, issue_dst_fmt,
    output result_valid, result_ready, result
  );
  modport slave (
    input issue_valid, issue_ready, issue_expected, issue_operands, issue_dst_fmt,
    input result_valid, result_ready, result
  );
endinterface

// File: rtl/fpu_sb_lane_cmp.sv
// fpu_sb_lane_cmp: combinational lane-wise result compare, optionally treating NaN lanes as equal.
module fpu_sb_lane_cmp
  import fpnew_pkg::*, fpu_sb_pkg::*;
#(
  parameter int unsigned WIDTH = SB_WIDTH
) (
  input  logic [WIDTH-1:0] i_expected,
  input  logic [WIDTH-1:0] i_got,
  input  fp_format_e       i_dst_fmt,
  input  logic             i_nan_lenient,
  output logic             o_equal
);
  localparam int unsigned MAX_LANES = WIDTH / 8;
  int unsigned w_lw;
  int unsigned w_nl;
  logic [63:0] w_mask;
  logic [63:0] w_e;
  logic [63:0] w_g;
  always_comb begin
    w_lw = fp_width(i_dst_fmt);
    w_nl = lanes(i_dst_fmt, WIDTH);
    w_mask = (64'd1 << w_lw) - 64'd1;
    w_e = '0;
    w_g = '0;
    o_equal = 1'b1;
    for (int unsigned l = 0; l < MAX_LANES; l++) begin
      w_e = 64'(i_expected >> (l * w_lw)) & w_mask;
      w_g = 64'(i_got >> (l * w_lw)) & w_mask;
      if (l < w_nl && w_e != w_g && !(i_nan_lenient && is_nan(w_e, i_dst_fmt) && is_nan(w_g, i_dst_fmt)))
        o_equal = 1'b0;
    end
    if (w_nl == 0) o_equal = (i_expected == i_got);
  end
endmodule

// File: rtl/fpu_result_scoreboard.sv
// fpu_result_scoreboard: in-order expected-result FIFO checking FPU results of any latency.
// Keeps pass/fail counters, last-failure capture and sticky protocol-error flags.
module fpu_result_scoreboard
  import fpnew_pkg::*, fpu_sb_pkg::*;
#(
  parameter int unsigned WIDTH          = SB_WIDTH,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          NAN_LENIENT    = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fpu_result_scoreboard_if.slave     bus,
  output logic                       o_mismatch,
  output logic [WIDTH-1:0]           o_mismatch_expected,
  output logic [WIDTH-1:0]           o_mismatch_got,
  output logic [3*WIDTH-1:0]         o_mismatch_operands,
  output logic [31:0]                o_pass_cnt,
  output logic [31:0]                o_fail_cnt,
  output logic [$clog2(DEPTH+1)-1:0] o_outstanding,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overflow,
  output logic                       o_underflow,
  output logic                       o_timeout
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  sb_entry_t          r_mem [DEPTH];
  logic [PW-1:0]      r_wr_ptr;
  logic [PW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [TW-1:0]      r_wd;
  logic               r_mismatch;
  logic [WIDTH-1:0]   r_mm_expected;
  logic [WIDTH-1:0]   r_mm_got;
  logic [3*WIDTH-1:0] r_mm_operands;
  logic [31:0]        r_pass;
  logic [31:0]        r_fail;
  logic               r_overflow;
  logic               r_underflow;
  logic               r_timeout;
  logic               w_push_hs;
  logic               w_pop_hs;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_equal;
  logic [TW-1:0]      w_wd_next;
  sb_entry_t          w_head;
  // A pop frees a slot in the same cycle, so push+pop while full is accepted.
  always_comb begin
    w_push_hs = bus.issue_valid && bus.issue_ready;
    w_pop_hs = bus.result_valid && bus.result_ready;
    w_empty = r_count == '0;
    w_full = r_count == CW'(DEPTH);
    w_pop = w_pop_hs && !w_empty;
    w_push = w_push_hs && (!w_full || w_pop);
    w_head = r_mem[r_rd_ptr];
    w_wd_next = (w_pop || w_empty) ? '0 : (r_wd == TW'(TIMEOUT_CYCLES)) ? r_wd : r_wd + 1'b1;
  end
  fpu_sb_lane_cmp #(.WIDTH(WIDTH)) u_lane_cmp (
    .i_expected    (w_head.expected),
    .i_got         (bus.result),
    .i_dst_fmt     (w_head.dst_fmt),
    .i_nan_lenient (NAN_LENIENT),
    .o_equal       (w_equal)
  );
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= '{expected: bus.issue_expected, operands: bus.issue_operands, dst_fmt: bus.issue_dst_fmt};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_wd          <= '0;
      r_mismatch    <= 1'b0;
      r_mm_expected <= '0;
      r_mm_got      <= '0;
      r_mm_operands <= '0;
      r_pass        <= '0;
      r_fail        <= '0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      r_wd        <= w_wd_next;
      r_timeout   <= r_timeout || (w_wd_next == TW'(TIMEOUT_CYCLES));
      r_overflow  <= r_overflow || (w_push_hs && w_full && !w_pop);
      r_underflow <= r_underflow || (w_pop_hs && w_empty);
      r_mismatch  <= w_pop && !w_equal;
      if (w_pop && w_equal && !(&r_pass)) r_pass <= r_pass + 1'b1;
      if (w_pop && !w_equal) begin
        if (!(&r_fail)) r_fail <= r_fail + 1'b1;
        r_mm_expected <= w_head.expected;
        r_mm_got      <= bus.result;
        r_mm_operands <= w_head.operands;
      end
    end
  end
  assign o_mismatch          = r_mismatch;
  assign o_mismatch_expected = r_mm_expected;
  assign o_mismatch_got      = r_mm_got;
  assign o_mismatch_operands = r_mm_operands;
  assign o_pass_cnt          = r_pass;
  assign o_fail_cnt          = r_fail;
  assign o_outstanding       = r_count;
  assign o_full              = w_full;
  assign o_empty             = w_empty;
  assign o_overflow          = r_overflow;
  assign o_underflow         = r_underflow;
  assign o_timeout           = r_timeout;
endmodule

// File: tb/tb_fpu_result_scoreboard.sv
// tb_fpu_result_scoreboard: directed stimulus against a queue-based reference model, lenient and strict instances.
module tb_fpu_result_scoreboard;
  import fpnew_pkg::*;
  localparam int W = 32, D = 8, TO = 64, CW = $clog2(D + 1);
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  fpu_result_scoreboard_if #(.WIDTH(W)) bus ();
  logic          mm [2];
  logic [W-1:0]  mme [2];
  logic [W-1:0]  mmg [2];
  logic [3*W-1:0] mmo [2];
  logic [31:0]   pc [2];
  logic [31:0]   fc [2];
  logic [CW-1:0] outs [2];
  logic          full [2], empty [2], ovf [2], unf [2], tmo [2];
  fpu_result_scoreboard #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(TO), .NAN_LENIENT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o_mismatch(mm[0]), .o_mismatch_expected(mme[0]), .o_mismatch_got(mmg[0]), .o_mismatch_operands(mmo[0]),
    .o_pass_cnt(pc[0]), .o_fail_cnt(fc[0]), .o_outstanding(outs[0]), .o_full(full[0]), .o_empty(empty[0]),
    .o_overflow(ovf[0]), .o_underflow(unf[0]), .o_timeout(tmo[0])
  );
  fpu_result_scoreboard #(.WIDTH(W), .DEPTH(D), .TIMEOUT_CYCLES(TO), .NAN_LENIENT(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .o_mismatch(mm[1]), .o_mismatch_expected(mme[1]), .o_mismatch_got(mmg[1]), .o_mismatch_operands(mmo[1]),
    .o_pass_cnt(pc[1]), .o_fail_cnt(fc[1]), .o_outstanding(outs[1]), .o_full(full[1]), .o_empty(empty[1]),
    .o_overflow(ovf[1]), .o_underflow(unf[1]), .o_timeout(tmo[1])
  );

  int n_tests = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Reference: lanes are equal when identical, or (lenient) when both magnitudes exceed infinity.
  function automatic bit model_eq(logic [31:0] e, logic [31:0] g, fp_format_e f, bit lenient);
    int lw, eb;
    logic [31:0] a, b, msk, inf;
    if (f == FP32) begin lw = 32; eb = 8; end
    else if (f == FP16) begin lw = 16; eb = 5; end
    else if (f == FP16ALT) begin lw = 16; eb = 8; end
    else if (f == FP8) begin lw = 8; eb = 5; end
    else if (f == FP8ALT) begin lw = 8; eb = 4; end
    else return e == g;
    msk = (lw == 32) ? 32'hffff_ffff : (32'd1 << lw) - 32'd1;
    inf = ((32'd1 << eb) - 32'd1) << (lw - 1 - eb);
    for (int k = 0; k < 32 / lw; k++) begin
      a = (e >> (k * lw)) & msk;
      b = (g >> (k * lw)) & msk;
      if (a != b && !(lenient && (a & (msk >> 1)) > inf && (b & (msk >> 1)) > inf)) return 1'b0;
    end
    return 1'b1;
  endfunction

  typedef struct {
    logic [31:0] e;
    logic [95:0] o;
    fp_format_e  f;
  } ent_t;
  ent_t q[$];
  logic [31:0] m_pass [2] = '{0, 0};
  logic [31:0] m_fail [2] = '{0, 0};
  logic        m_mm [2] = '{0, 0};
  logic [31:0] m_mme [2] = '{0, 0};
  logic [31:0] m_mmg [2] = '{0, 0};
  logic [95:0] m_mmo [2] = '{0, 0};
  bit m_ovf = 0, m_unf = 0, m_tmo = 0;
  int m_wd = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      for (int v = 0; v < 2; v++) begin
        m_pass[v] = 0; m_fail[v] = 0; m_mm[v] = 0; m_mme[v] = 0; m_mmg[v] = 0; m_mmo[v] = 0;
      end
      m_ovf = 0; m_unf = 0; m_tmo = 0; m_wd = 0;
    end else begin
      bit push, pop;
      int sz;
      ent_t h;
      push = bus.issue_valid && bus.issue_ready;
      pop = bus.result_valid && bus.result_ready;
      sz = q.size();
      for (int v = 0; v < 2; v++) m_mm[v] = 0;
      if (pop && sz == 0) m_unf = 1;
      else if (pop) begin
        h = q.pop_front();
        for (int v = 0; v < 2; v++)
          if (model_eq(h.e, bus.result, h.f, v == 0)) begin
            if (m_pass[v] != '1) m_pass[v]++;
          end else begin
            if (m_fail[v] != '1) m_fail[v]++;
            m_mm[v] = 1; m_mme[v] = h.e; m_mmg[v] = bus.result; m_mmo[v] = h.o;
          end
      end
      if (push) begin
        if (q.size() < D) q.push_back('{bus.issue_expected, bus.issue_operands, bus.issue_dst_fmt});
        else m_ovf = 1;
      end
      if (pop || sz == 0) m_wd = 0;
      else if (m_wd < TO) m_wd++;
      if (m_wd == TO) m_tmo = 1;
    end
  end

  always @(negedge clk) if (rst_n) begin
    for (int v = 0; v < 2; v++) begin
      chk($sformatf("mismatch[%0d]", v), mm[v], m_mm[v]);
      chk($sformatf("mm_expected[%0d]", v), mme[v], m_mme[v]);
      chk($sformatf("mm_got[%0d]", v), mmg[v], m_mmg[v]);
      chk($sformatf("mm_operands[%0d]", v), mmo[v], m_mmo[v]);
      chk($sformatf("pass_cnt[%0d]", v), pc[v], m_pass[v]);
      chk($sformatf("fail_cnt[%0d]", v), fc[v], m_fail[v]);
      chk($sformatf("outstanding[%0d]", v), outs[v], 128'(q.size()));
      chk($sformatf("full[%0d]", v), full[v], q.size() == D);
      chk($sformatf("empty[%0d]", v), empty[v], q.size() == 0);
      chk($sformatf("overflow[%0d]", v), ovf[v], m_ovf);
      chk($sformatf("underflow[%0d]", v), unf[v], m_unf);
      chk($sformatf("timeout[%0d]", v), tmo[v], m_tmo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic cyc(input logic iv, input logic [31:0] e, input logic [95:0] o, input fp_format_e f,
                     input logic rv, input logic [31:0] r);
    bus.issue_valid = iv; bus.issue_ready = 1'b1; bus.issue_expected = e; bus.issue_operands = o; bus.issue_dst_fmt = f;
    bus.result_valid = rv; bus.result_ready = 1'b1; bus.result = r;
    tick();
    bus.issue_valid = 1'b0; bus.result_valid = 1'b0;
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    bus.issue_valid = 1'b0; bus.result_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [31:0] v8_exp [4] = '{32'h6aed7c54, 32'h6aed7c55, 32'h6aed7c56, 32'h6aed7c57};
  logic [31:0] v8_got [4] = '{32'h6aed7c54, 32'h6aed7c55, 32'h6aed7c57, 32'h6aed7c57};
  fp_format_e  vt_fmt [8] = '{FP32, FP16, FP16ALT, FP8ALT, FP64, FP32, FP8, FP32};
  logic [31:0] vt_exp [8] = '{32'h3f800000, 32'h7e003c00, 32'h7fc13f80, 32'h0000007f,
                              32'h7fc00000, 32'h7f800000, 32'h00007c00, 32'h7fc00000};
  logic [31:0] vt_got [8] = '{32'h3f800000, 32'h7c013c00, 32'h7f813f80, 32'h00000079,
                              32'h7fc00001, 32'h7fc00000, 32'h00007d00, 32'h7f800001};
  bit vt_len [8] = '{1, 1, 1, 1, 0, 0, 0, 1};

  initial begin
    bus.issue_valid = 1'b0; bus.issue_ready = 1'b0; bus.issue_expected = '0; bus.issue_operands = '0;
    bus.issue_dst_fmt = FP32; bus.result_valid = 1'b0; bus.result_ready = 1'b0; bus.result = '0;
    do_reset();
    chk("reset_empty", empty[0], 1'b1);
    chk("reset_outstanding", outs[0], 0);
    chk("reset_pass", pc[0], 0);
    chk("reset_mismatch", mm[0], 1'b0);

    cyc(1, 32'h3f800000, 96'h1, FP32, 0, 0);
    cyc(0, 0, 0, FP32, 1, 32'h3f800000);
    chk("fp32_pass", pc[0], 1);
    chk("fp32_fail", fc[0], 0);
    chk("fp32_empty", empty[0], 1'b1);

    do_reset();
    for (int c = 0; c < 7; c++) begin
      cyc(c < 4, (c < 4) ? v8_exp[c % 4] : 32'h0, {32'(c), 32'ha0 + 32'(c), 32'hb0 + 32'(c)}, FP8,
          c >= 3, (c >= 3) ? v8_got[(c + 1) % 4] : 32'h0);
      if (c == 5) begin
        chk("fp8_mismatch_pulse", mm[0], 1'b1);
        chk("fp8_mm_got", mmg[0], 32'h6aed7c57);
        chk("fp8_mm_expected", mme[0], 32'h6aed7c56);
        chk("fp8_mm_operands", mmo[0], {32'd2, 32'ha2, 32'hb2});
      end
    end
    chk("fp8_pass", pc[0], 3);
    chk("fp8_fail", fc[0], 1);
    chk("fp8_empty", empty[0], 1'b1);

    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(1, vt_exp[i], {3{32'(i)}}, vt_fmt[i], 0, 0);
      cyc(0, 0, 0, FP32, 1, vt_got[i]);
      chk($sformatf("model_len[%0d]", i), model_eq(vt_exp[i], vt_got[i], vt_fmt[i], 1), vt_len[i]);
      chk($sformatf("model_strict[%0d]", i), model_eq(vt_exp[i], vt_got[i], vt_fmt[i], 0), i == 0);
    end
    chk("lanes_len_pass", pc[0], 5);
    chk("lanes_len_fail", fc[0], 3);
    chk("lanes_strict_pass", pc[1], 1);
    chk("lanes_strict_fail", fc[1], 7);

    do_reset();
    for (int i = 0; i < D; i++) cyc(1, 32'h1000 + 32'(i), 96'(i), FP32, 0, 0);
    chk("fill_full", full[0], 1'b1);
    chk("fill_outstanding", outs[0], D);
    chk("fill_overflow", ovf[0], 1'b0);
    cyc(1, 32'h1000 + D, 96'(D), FP32, 1, 32'h1000);
    chk("full_pushpop_outstanding", outs[0], D);
    chk("full_pushpop_overflow", ovf[0], 1'b0);
    chk("full_pushpop_pass", pc[0], 1);
    cyc(1, 32'h2000, 96'h2000, FP32, 0, 0);
    chk("overflow_flag", ovf[0], 1'b1);
    chk("overflow_outstanding", outs[0], D);
    for (int i = 1; i <= D; i++) cyc(0, 0, 0, FP32, 1, 32'h1000 + 32'(i));
    chk("drain_pass", pc[0], D + 1);
    chk("drain_fail", fc[0], 0);
    chk("drain_empty", empty[0], 1'b1);

    do_reset();
    cyc(0, 0, 0, FP32, 1, 32'h1234);
    chk("underflow_flag", unf[0], 1'b1);
    chk("underflow_pass", pc[0], 0);
    chk("underflow_fail", fc[0], 0);
    cyc(1, 32'habc, 96'habc, FP32, 1, 32'habc);
    chk("empty_pushpop_outstanding", outs[0], 1);
    chk("empty_pushpop_pass", pc[0], 0);
    cyc(0, 0, 0, FP32, 1, 32'habc);
    chk("empty_pushpop_drain", pc[0], 1);

    do_reset();
    cyc(1, 32'h40000000, 96'h7, FP32, 0, 0);
    cyc(0, 0, 0, FP32, 1, 32'h40000000);
    cyc(1, 32'h55, 96'h55, FP32, 0, 0);
    repeat (TO - 1) tick();
    chk("timeout_before", tmo[0], 1'b0);
    tick();
    chk("timeout_at_limit", tmo[0], 1'b1);
    chk("timeout_outstanding", outs[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_timeout", tmo[0], 1'b0);
    chk("async_rst_pass", pc[0], 0);
    chk("async_rst_outstanding", outs[0], 0);
    chk("async_rst_empty", empty[0], 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, limit %0d", 1000000);
    $fatal(1);
  end
endmodule
